// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: opcodes, function
// codes, FSM states, datapath select values and the decoded-instruction record.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic SEL_RD      = 1'b1;
  localparam logic SEL_RT      = 1'b0;
  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;
  localparam logic WB_SRC_ALU  = 1'b0;
  localparam logic WB_SRC_MEM  = 1'b1;

  typedef logic [2:0] mem_size_t;
  localparam mem_size_t SIZE_NONE = 3'b000;
  localparam mem_size_t SIZE_WORD = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_RTYPE, CLS_ADDI, CLS_LW, CLS_SW
  } instr_cls_e;

  typedef struct packed {
    logic       legal;
    instr_cls_e cls;
    logic [5:0] alu_func;
  } dec_t;

  function automatic logic is_rtype_func(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_XOR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Memory-side handshake bundle of mc_sequencer: instruction fetch and data access.
interface mc_sequencer_if;
  import mips_ctrl_pkg::*;

  logic      imem_re_out;
  logic      imem_ready_in;
  logic      data_mem_re_out;
  logic      data_mem_we_out;
  mem_size_t data_mem_size_out;
  logic      data_mem_ready_in;

  modport master (
    output imem_re_out, data_mem_re_out, data_mem_we_out, data_mem_size_out,
    input  imem_ready_in, data_mem_ready_in
  );

  modport slave (
    input  imem_re_out, data_mem_re_out, data_mem_we_out, data_mem_size_out,
    output imem_ready_in, data_mem_ready_in
  );
endinterface

// File: rtl/mc_decode.sv
// Purely combinational instruction decoder: opcode/func to legality, class and ALU function.
module mc_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '{legal: 1'b0, cls: CLS_NONE, alu_func: 6'b000000};
    case (opcode_i)
      OP_RTYPE: if (is_rtype_func(func_i)) dec_o = '{legal: 1'b1, cls: CLS_RTYPE, alu_func: func_i};
      OP_ADDI:  dec_o = '{legal: 1'b1, cls: CLS_ADDI, alu_func: FN_ADD};
      OP_LW:    dec_o = '{legal: 1'b1, cls: CLS_LW,   alu_func: FN_ADD};
      OP_SW:    dec_o = '{legal: 1'b1, cls: CLS_SW,   alu_func: FN_ADD};
      default:  ;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB) with data-memory timeout.
// Define SEQ_RETIRE_CNT_EN to build the retired-instruction counter; otherwise it reads 0.
module mc_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             run_in,
  output logic             busy_out,
  input  logic [5:0]       opcode_in,
  input  logic [5:0]       func_in,
  output logic             ir_load_out,
  output logic             pc_enable_out,
  output logic             instr_mux_select_out,
  output logic             regfile_we_out,
  output logic             alu_mux_select_out,
  output logic [5:0]       alu_func_out,
  output logic             data_mem_mux_select_out,
  output logic             illegal_instr_out,
  output logic             bus_error_out,
  output logic [CNT_W-1:0] retire_count_out,
  mc_sequencer_if.master   mem_if
);

  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  instr_cls_e       cls_q, cls_d;
  logic [5:0]       alu_func_q, alu_func_d;
  logic [TMO_W-1:0] mem_cnt_q, mem_cnt_d;
  logic             bus_err_q, bus_err_d;

  dec_t      dec;
  logic      mem_timeout;
  logic      in_dp;
  logic      imem_re, dmem_re, dmem_we;
  mem_size_t dmem_size;

  mc_decode u_decode (
    .opcode_i (opcode_in),
    .func_i   (func_in),
    .dec_o    (dec)
  );

  // Last permitted MEM cycle without ready; a ready on this very cycle still completes.
  assign mem_timeout = (state_q == ST_MEM) && !mem_if.data_mem_ready_in && (mem_cnt_q == TMO_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      cls_q      <= CLS_NONE;
      alu_func_q <= '0;
      mem_cnt_q  <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      alu_func_q <= alu_func_d;
      mem_cnt_q  <= mem_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    alu_func_d = alu_func_q;
    mem_cnt_d  = mem_cnt_q;
    bus_err_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (run_in) state_d = ST_FETCH;
      ST_FETCH: if (mem_if.imem_ready_in) state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d      = dec.cls;
        alu_func_d = dec.alu_func;
        if (dec.legal) state_d = ST_EXEC;
        else           state_d = run_in ? ST_FETCH : ST_IDLE;
      end
      ST_EXEC: begin
        mem_cnt_d = '0;
        state_d   = (cls_q == CLS_LW || cls_q == CLS_SW) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (mem_if.data_mem_ready_in) begin
          state_d = ST_WB;
        end else if (mem_timeout) begin
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          mem_cnt_d = mem_cnt_q + TMO_W'(1);
        end
      end
      ST_WB:   state_d = run_in ? ST_FETCH : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the illegal-instruction strobe in DECODE looks at the live decoder; all
  // datapath controls come from the decode registers captured on leaving DECODE.
  always_comb begin
    imem_re                 = 1'b0;
    ir_load_out             = 1'b0;
    dmem_re                 = 1'b0;
    dmem_we                 = 1'b0;
    dmem_size               = SIZE_NONE;
    pc_enable_out           = 1'b0;
    illegal_instr_out       = 1'b0;
    regfile_we_out          = 1'b0;
    instr_mux_select_out    = SEL_RT;
    alu_mux_select_out      = ALU_SRC_REG;
    alu_func_out            = 6'b000000;
    data_mem_mux_select_out = WB_SRC_ALU;
    in_dp                   = state_q inside {ST_EXEC, ST_MEM, ST_WB};
    case (state_q)
      ST_FETCH: begin
        imem_re     = 1'b1;
        ir_load_out = mem_if.imem_ready_in;
      end
      ST_DECODE: begin
        illegal_instr_out = !dec.legal;
        pc_enable_out     = !dec.legal;
      end
      ST_MEM: begin
        dmem_re = (cls_q == CLS_LW);
        dmem_we = (cls_q == CLS_SW);
      end
      ST_WB: begin
        pc_enable_out  = 1'b1;
        regfile_we_out = cls_q inside {CLS_RTYPE, CLS_ADDI, CLS_LW};
      end
      default: ;
    endcase
    if (in_dp) begin
      instr_mux_select_out    = (cls_q == CLS_RTYPE) ? SEL_RD : SEL_RT;
      alu_mux_select_out      = (cls_q == CLS_RTYPE) ? ALU_SRC_REG : ALU_SRC_IMM;
      alu_func_out            = alu_func_q;
      dmem_size               = (cls_q == CLS_LW || cls_q == CLS_SW) ? SIZE_WORD : SIZE_NONE;
      data_mem_mux_select_out = (cls_q == CLS_LW) ? WB_SRC_MEM : WB_SRC_ALU;
    end
  end

  assign busy_out                 = (state_q != ST_IDLE);
  assign bus_error_out            = bus_err_q;
  assign mem_if.imem_re_out       = imem_re;
  assign mem_if.data_mem_re_out   = dmem_re;
  assign mem_if.data_mem_we_out   = dmem_we;
  assign mem_if.data_mem_size_out = dmem_size;

`ifdef SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q;
    if (state_q == ST_WB) retire_d = retire_q + CNT_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) retire_q <= '0;
    else           retire_q <= retire_d;
  end

  assign retire_count_out = retire_q;
`else
  assign retire_count_out = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed corner cases plus randomized
// instructions and memory wait states, checked against a transaction-level model.
module tb_mc_sequencer;

  localparam int TMO = 15;
  localparam int CW  = 32;

`ifdef SEQ_RETIRE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          run_in;
  logic          busy_out;
  logic [5:0]    opcode_in;
  logic [5:0]    func_in;
  logic          ir_load_out;
  logic          pc_enable_out;
  logic          instr_mux_select_out;
  logic          regfile_we_out;
  logic          alu_mux_select_out;
  logic [5:0]    alu_func_out;
  logic          data_mem_mux_select_out;
  logic          illegal_instr_out;
  logic          bus_error_out;
  logic [CW-1:0] retire_count_out;

  mc_sequencer_if mem_if ();

  mc_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_in                  (clk_in),
    .rst_n_in                (rst_n_in),
    .run_in                  (run_in),
    .busy_out                (busy_out),
    .opcode_in               (opcode_in),
    .func_in                 (func_in),
    .ir_load_out             (ir_load_out),
    .pc_enable_out           (pc_enable_out),
    .instr_mux_select_out    (instr_mux_select_out),
    .regfile_we_out          (regfile_we_out),
    .alu_mux_select_out      (alu_mux_select_out),
    .alu_func_out            (alu_func_out),
    .data_mem_mux_select_out (data_mem_mux_select_out),
    .illegal_instr_out       (illegal_instr_out),
    .bus_error_out           (bus_error_out),
    .retire_count_out        (retire_count_out),
    .mem_if                  (mem_if)
  );

  always #5 clk_in = ~clk_in;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [CW-1:0] retire_exp;
  logic [5:0]    nxt_op, nxt_fn;
  bit            ld_pend;
  int            fcnt, dcnt, iw_cur, dw_cur;

  typedef struct {
    int         busy, pc_en, illegal, rf_we, re, we, berr, fetch, wb_idx;
    logic [5:0] func;
    logic       imux, amux, dmux;
    logic [2:0] size;
    bit         retire;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction as a whole: how many cycles each strobe is seen and what the
  // WB cycle carries, from the ISA table and the memory wait counts.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input int iw, input int dw);
    exp_t e;
    bit r, addi, lw, sw, tmo;
    int mem;
    r    = (op == 6'd0) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26});
    addi = (op == 6'd8);
    lw   = (op == 6'd35);
    sw   = (op == 6'd43);
    e = '{busy: 0, pc_en: 0, illegal: 0, rf_we: 0, re: 0, we: 0, berr: 0, fetch: iw + 1,
          wb_idx: -1, func: 6'd0, imux: 1'b0, amux: 1'b0, dmux: 1'b0, size: 3'd0, retire: 1'b0};
    if (!(r || addi || lw || sw)) begin
      e.busy = e.fetch + 1;
      e.pc_en = 1;
      e.illegal = 1;
    end else begin
      tmo = (lw || sw) && (dw >= TMO);
      mem = (lw || sw) ? (tmo ? TMO : dw + 1) : 0;
      e.busy = e.fetch + 2 + mem + (tmo ? 0 : 1);
      e.re = lw ? mem : 0;
      e.we = sw ? mem : 0;
      e.berr = tmo ? 1 : 0;
      if (!tmo) begin
        e.pc_en  = 1;
        e.rf_we  = sw ? 0 : 1;
        e.wb_idx = e.fetch + 2 + mem;
        e.func   = r ? fn : 6'h20;
        e.imux   = r;
        e.amux   = !r;
        e.dmux   = lw;
        e.size   = (lw || sw) ? 3'b011 : 3'b000;
        e.retire = 1'b1;
      end
    end
    return e;
  endfunction

  // Called just after a rising edge: loads the IR, answers the memories, then settles.
  task automatic drive_cycle();
    if (ld_pend) begin
      opcode_in = nxt_op;
      func_in   = nxt_fn;
      ld_pend   = 1'b0;
    end
    mem_if.imem_ready_in = mem_if.imem_re_out && (fcnt == iw_cur);
    if (mem_if.imem_re_out) fcnt = mem_if.imem_ready_in ? 0 : fcnt + 1;
    mem_if.data_mem_ready_in = (mem_if.data_mem_re_out || mem_if.data_mem_we_out) && (dcnt == dw_cur);
    if (mem_if.data_mem_re_out || mem_if.data_mem_we_out) dcnt = mem_if.data_mem_ready_in ? 0 : dcnt + 1;
    #1;
    if (ir_load_out) ld_pend = 1'b1;
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn, input int iw, input int dw);
    exp_t e;
    int busy, pc, ill, rf, re, we, be, ifc, ld, wbi, cyc;
    logic [5:0] wf;
    logic wim, wam, wdm;
    logic [2:0] wsz;
    bit done;
    e = model(op, fn, iw, dw);
    nxt_op = op; nxt_fn = fn; iw_cur = iw; dw_cur = dw; fcnt = 0; dcnt = 0;
    busy = 0; pc = 0; ill = 0; rf = 0; re = 0; we = 0; be = 0; ifc = 0; ld = 0; wbi = -1;
    wf = 6'd0; wim = 1'b0; wam = 1'b0; wdm = 1'b0; wsz = 3'd0; done = 1'b0; cyc = 0;
    run_in = 1'b1;
    @(posedge clk_in); #1;
    run_in = 1'b0;
    while (!done && cyc < 400) begin
      drive_cycle();
      if (busy_out) busy++;
      if (pc_enable_out) pc++;
      if (illegal_instr_out) ill++;
      if (regfile_we_out) rf++;
      if (mem_if.data_mem_re_out) re++;
      if (mem_if.data_mem_we_out) we++;
      if (bus_error_out) be++;
      if (mem_if.imem_re_out) ifc++;
      if (ir_load_out) ld++;
      if (pc_enable_out && !illegal_instr_out) begin
        wbi = cyc; wf = alu_func_out; wim = instr_mux_select_out; wam = alu_mux_select_out;
        wdm = data_mem_mux_select_out; wsz = mem_if.data_mem_size_out;
      end
      if (!busy_out) done = 1'b1;
      cyc++;
      @(posedge clk_in); #1;
    end
    if (e.retire && CNT_ON) retire_exp = retire_exp + 1'b1;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, busy, e.busy);
    chk({tag, "_fetch"}, ifc, e.fetch);
    chk({tag, "_irload"}, ld, 1);
    chk({tag, "_pcen"}, pc, e.pc_en);
    chk({tag, "_illegal"}, ill, e.illegal);
    chk({tag, "_rfwe"}, rf, e.rf_we);
    chk({tag, "_re"}, re, e.re);
    chk({tag, "_we"}, we, e.we);
    chk({tag, "_buserr"}, be, e.berr);
    chk({tag, "_wbidx"}, wbi, e.wb_idx);
    chk({tag, "_func"}, 32'(wf), 32'(e.func));
    chk({tag, "_imux"}, 32'(wim), 32'(e.imux));
    chk({tag, "_amux"}, 32'(wam), 32'(e.amux));
    chk({tag, "_dmux"}, 32'(wdm), 32'(e.dmux));
    chk({tag, "_size"}, 32'(wsz), 32'(e.size));
    chk({tag, "_retire"}, retire_count_out, retire_exp);
  endtask

  initial begin
    logic [5:0] rfn [6];
    logic [5:0] op, fn;
    int k, iw, dw, cyc, wbs, first, last, ifc;
    bit seen;
    rfn[0] = 6'h20; rfn[1] = 6'h22; rfn[2] = 6'h24; rfn[3] = 6'h25; rfn[4] = 6'h27; rfn[5] = 6'h26;
    rst_n_in = 1'b0; run_in = 1'b0; opcode_in = 6'd0; func_in = 6'd0;
    mem_if.imem_ready_in = 1'b0; mem_if.data_mem_ready_in = 1'b0;
    ld_pend = 1'b0; fcnt = 0; dcnt = 0; iw_cur = 0; dw_cur = 0;
    nxt_op = 6'd0; nxt_fn = 6'd0; retire_exp = '0;
    #2;
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_imem_re", 32'(mem_if.imem_re_out), 0);
    chk("rst_irload", 32'(ir_load_out), 0);
    chk("rst_pcen", 32'(pc_enable_out), 0);
    chk("rst_rfwe", 32'(regfile_we_out), 0);
    chk("rst_dre", 32'(mem_if.data_mem_re_out), 0);
    chk("rst_dwe", 32'(mem_if.data_mem_we_out), 0);
    chk("rst_size", 32'(mem_if.data_mem_size_out), 0);
    chk("rst_func", 32'(alu_func_out), 0);
    chk("rst_illegal", 32'(illegal_instr_out), 0);
    chk("rst_buserr", 32'(bus_error_out), 0);
    chk("rst_retire", retire_count_out, 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;

    do_instr("add", 6'd0, 6'h20, 0, 0);
    do_instr("lw_wait3", 6'd35, 6'd0, 0, 3);
    do_instr("sw_timeout", 6'd43, 6'd0, 0, 1000);
    do_instr("sw_last_cycle", 6'd43, 6'd0, 1, TMO - 1);
    do_instr("lw_at_timeout", 6'd35, 6'd0, 0, TMO);
    do_instr("illegal_op", 6'h3f, 6'h20, 0, 0);
    do_instr("illegal_fn", 6'd0, 6'h21, 2, 0);
    do_instr("addi_wait", 6'd8, 6'h3f, 3, 0);

    for (int t = 0; t < 30; t++) begin
      k  = $urandom_range(0, 11);
      iw = $urandom_range(0, 3);
      dw = ($urandom_range(0, 4) == 0) ? (TMO - 1 + $urandom_range(0, 2)) : $urandom_range(0, 3);
      fn = 6'($urandom);
      case (k)
        0, 1, 2, 3, 4, 5: begin op = 6'd0; fn = rfn[k]; end
        6:       op = 6'd8;
        7:       op = 6'd35;
        8:       op = 6'd43;
        9:       op = 6'd0;
        default: op = 6'($urandom);
      endcase
      do_instr($sformatf("rnd%0d", t), op, fn, iw, dw);
    end

    // Reset while a load is waiting in MEM
    nxt_op = 6'd35; nxt_fn = 6'd0; iw_cur = 0; dw_cur = 1000; fcnt = 0; dcnt = 0;
    run_in = 1'b1;
    @(posedge clk_in); #1;
    run_in = 1'b0; seen = 1'b0; cyc = 0;
    while (!seen && cyc < 50) begin
      drive_cycle();
      seen = mem_if.data_mem_re_out;
      if (!seen) begin
        @(posedge clk_in); #1;
      end
      cyc++;
    end
    chk("mid_mem_reached", 32'(seen), 1);
    rst_n_in = 1'b0;
    #1;
    retire_exp = '0;
    chk("mid_mem_rst_re", 32'(mem_if.data_mem_re_out), 0);
    chk("mid_mem_rst_busy", 32'(busy_out), 0);
    chk("mid_mem_rst_size", 32'(mem_if.data_mem_size_out), 0);
    chk("mid_mem_rst_retire", retire_count_out, retire_exp);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    mem_if.imem_ready_in = 1'b0; mem_if.data_mem_ready_in = 1'b0;
    ld_pend = 1'b0; fcnt = 0; dcnt = 0;

    // Ten back-to-back adds with run held high
    nxt_op = 6'd0; nxt_fn = 6'h20; iw_cur = 0; dw_cur = 0;
    wbs = 0; first = -1; last = -1; ifc = 0;
    run_in = 1'b1;
    @(posedge clk_in); #1;
    for (int i = 0; i < 40; i++) begin
      run_in = (i < 39);
      drive_cycle();
      if (mem_if.imem_re_out) ifc++;
      if (pc_enable_out && regfile_we_out) begin
        wbs++;
        if (first < 0) first = i;
        last = i;
      end
      @(posedge clk_in); #1;
    end
    if (CNT_ON) retire_exp = 10;
    chk("b2b_wb_count", wbs, 10);
    chk("b2b_first_wb", first, 3);
    chk("b2b_last_wb", last, 39);
    chk("b2b_fetches", ifc, 10);
    chk("b2b_idle", 32'(busy_out), 0);
    chk("b2b_retire", retire_count_out, retire_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
